// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters
// (CPU load/store port, VGA pixel fetch) and the data memory array.
interface dmem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [1:0]  cpu_size;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_err;

    logic        vga_req;
    logic [31:0] vga_addr;
    logic        vga_gnt;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        input  vga_req, vga_addr,
        output vga_gnt, vga_rvalid, vga_rdata,
        output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );

    // Requesters and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_size,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
        output vga_req, vga_addr,
        input  vga_gnt, vga_rvalid, vga_rdata,
        input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU single accesses vs VGA read bursts,
// with a starvation bound for the CPU and big-endian byte enables.
module dmem_arbiter #(
    parameter int BURST_LEN    = 8,
    parameter int STARVE_LIMIT = 16
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CPU, VGA} state_t;

    state_t      state_q, state_d;
    logic [5:0]  starve_cnt_q, starve_cnt_d;
    logic [6:0]  beat_q, beat_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cpu_gnt_q, cpu_gnt_d;
    logic        cpu_err_q, cpu_err_d;
    logic        vga_gnt_q, vga_gnt_d;
    logic        cpu_rvalid_q, cpu_rvalid_d;
    logic        vga_rvalid_q, vga_rvalid_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] vga_rdata_q, vga_rdata_d;

    logic        cpu_misaligned;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_lanes;
    logic        vga_wins;

    // Size/offset decode: alignment, byte lanes and replicated store data
    always_comb begin
        cpu_misaligned = 1'b0;
        cpu_be         = 4'b1111;
        cpu_lanes      = bus.cpu_wdata;
        unique case (bus.cpu_size)
            2'd0: begin
                cpu_be    = 4'b1000 >> bus.cpu_addr[1:0];
                cpu_lanes = {4{bus.cpu_wdata[7:0]}};
            end
            2'd1: begin
                cpu_misaligned = bus.cpu_addr[0];
                cpu_be         = bus.cpu_addr[1] ? 4'b0011 : 4'b1100;
                cpu_lanes      = {2{bus.cpu_wdata[15:0]}};
            end
            default: begin
                cpu_misaligned = |bus.cpu_addr[1:0];
            end
        endcase
        if (!bus.cpu_we) begin
            cpu_be = 4'b1111;
        end
    end

    assign vga_wins = bus.vga_req &&
        ((int'(starve_cnt_q) < STARVE_LIMIT) || !bus.cpu_req);

    // Saturating count of cycles the CPU has been kept waiting
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.cpu_req || cpu_gnt_q) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != 6'h3f) begin
            starve_cnt_d = starve_cnt_q + 6'd1;
        end
    end

    // Arbitration FSM; every memory-side output is computed one cycle ahead
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        cpu_gnt_d   = 1'b0;
        cpu_err_d   = 1'b0;
        vga_gnt_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (vga_wins) begin
                    state_d    = VGA;
                    beat_d     = 7'd1;
                    mem_en_d   = 1'b1;
                    mem_be_d   = 4'b1111;
                    mem_addr_d = {bus.vga_addr[31:2], 2'b00};
                    vga_gnt_d  = 1'b1;
                end else if (bus.cpu_req) begin
                    state_d   = CPU;
                    cpu_gnt_d = 1'b1;
                    cpu_err_d = cpu_misaligned;
                    if (!cpu_misaligned) begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.cpu_we;
                        mem_be_d    = cpu_be;
                        mem_addr_d  = {bus.cpu_addr[31:2], 2'b00};
                        mem_wdata_d = cpu_lanes;
                    end
                end
            end
            CPU: begin
                state_d = IDLE;
            end
            VGA: begin
                if (beat_q == 7'(BURST_LEN)) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else begin
                    beat_d     = beat_q + 7'd1;
                    mem_en_d   = 1'b1;
                    mem_be_d   = 4'b1111;
                    mem_addr_d = mem_addr_q + 32'd4;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read-return pipeline: one bit per requester, data captured on return
    always_comb begin
        cpu_rvalid_d = mem_en_q && !mem_we_q && (state_q == CPU);
        vga_rvalid_d = mem_en_q && (state_q == VGA);
        cpu_rdata_d  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
        vga_rdata_d  = vga_rvalid_q ? bus.mem_rdata : vga_rdata_q;
    end

    // All state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            beat_q       <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_gnt_q    <= 1'b0;
            cpu_err_q    <= 1'b0;
            vga_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            vga_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            vga_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            beat_q       <= beat_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            cpu_err_q    <= cpu_err_d;
            vga_gnt_q    <= vga_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            vga_rvalid_q <= vga_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vga_rdata_q  <= vga_rdata_d;
        end
    end

    // Returned data is passed straight through in the rvalid cycle
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
    assign bus.vga_rdata  = vga_rvalid_q ? bus.mem_rdata : vga_rdata_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.vga_rvalid = vga_rvalid_q;
    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.cpu_err    = cpu_err_q;
    assign bus.vga_gnt    = vga_gnt_q;
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: byte-level shadow memory model, directed
// scenarios and randomized CPU/VGA traffic.
module tb_dmem_arbiter;
    localparam int BL = 8;
    localparam int SL = 16;

    logic clk = 1'b0;
    logic reset;
    logic mem_init;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [31:0] mem_arr [64];
    logic [7:0]  sh [256];

    always #5 clk = ~clk;

    dmem_arbiter_if bus();

    dmem_arbiter #(.BURST_LEN(BL), .STARVE_LIMIT(SL)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    function automatic logic [31:0] init_word(input int i);
        return {8'(i), 8'(i * 3 + 5), 8'(i * 7 + 1), 8'(255 - i)};
    endfunction

    // Data memory: byte-enable writes, one-cycle read latency
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.mem_be[b])
                        mem_arr[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
            end else begin
                bus.mem_rdata <= mem_arr[bus.mem_addr[7:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sh_word(input logic [31:0] a);
        logic [7:0] base;
        base = {a[7:2], 2'b00};
        return {sh[base], sh[8'(base + 8'd1)], sh[8'(base + 8'd2)], sh[8'(base + 8'd3)]};
    endfunction

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_en"}, 32'(bus.mem_en), 32'd0);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
        chk({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_cpu_gnt"}, 32'(bus.cpu_gnt), 32'd0);
        chk({tag, "_vga_gnt"}, 32'(bus.vga_gnt), 32'd0);
        chk({tag, "_cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'd0);
        chk({tag, "_vga_rvalid"}, 32'(bus.vga_rvalid), 32'd0);
        chk({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'd0);
        chk({tag, "_vga_rdata"}, bus.vga_rdata, 32'd0);
        chk({tag, "_cpu_err"}, 32'(bus.cpu_err), 32'd0);
    endtask

    task automatic cpu_access(input logic we, input logic [1:0] size,
                              input logic [31:0] a, input logic [31:0] d);
        int          nb, w, off;
        logic        err;
        logic [3:0]  be;
        logic [31:0] lanes, expd;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        err = (nb == 2 && a[0]) || (nb == 4 && off != 0);
        be  = 4'b0000;
        for (int o = 0; o < 4; o++)
            if (o >= off && o < off + nb) be[3-o] = 1'b1;
        if (!we) be = 4'b1111;
        lanes = (nb == 1) ? {4{d[7:0]}} : (nb == 2) ? {2{d[15:0]}} : d;
        bus.cpu_we    = we;
        bus.cpu_size  = size;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        bus.cpu_req   = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.cpu_gnt && w < 20);
        bus.cpu_req = 1'b0;
        chk("cpu_latency", 32'(w), 32'd1);
        chk("cpu_err", 32'(bus.cpu_err), 32'(err));
        chk("cpu_mem_en", 32'(bus.mem_en), 32'(!err));
        if (!err) begin
            chk("cpu_mem_we", 32'(bus.mem_we), 32'(we));
            chk("cpu_mem_addr", bus.mem_addr, {a[31:2], 2'b00});
            chk("cpu_mem_be", 32'(bus.mem_be), 32'(be));
            if (we) chk("cpu_mem_wdata", bus.mem_wdata, lanes);
        end
        if (we && !err)
            for (int k = 0; k < nb; k++)
                sh[8'(int'(a[7:0]) + k)] = 8'(d >> (8 * (nb - 1 - k)));
        expd = sh_word(a);
        @(negedge clk);
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!we && !err));
        if (!we && !err) chk("cpu_rdata", bus.cpu_rdata, expd);
    endtask

    task automatic vga_burst(input logic [31:0] a);
        int w;
        bus.vga_addr = a;
        bus.vga_req  = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.vga_gnt && w < 20);
        bus.vga_req = 1'b0;
        chk("vga_latency", 32'(w), 32'd1);
        for (int i = 0; i < BL; i++) begin
            if (i > 0) @(negedge clk);
            chk("vga_gnt", 32'(bus.vga_gnt), 32'(i == 0));
            chk("vga_mem_en", 32'(bus.mem_en), 32'd1);
            chk("vga_mem_we", 32'(bus.mem_we), 32'd0);
            chk("vga_mem_addr", bus.mem_addr, a + 32'(4 * i));
            chk("vga_rvalid", 32'(bus.vga_rvalid), 32'(i > 0));
            if (i > 0) chk("vga_rdata", bus.vga_rdata, sh_word(a + 32'(4 * (i - 1))));
        end
        @(negedge clk);
        chk("vga_end_mem_en", 32'(bus.mem_en), 32'd0);
        chk("vga_last_rvalid", 32'(bus.vga_rvalid), 32'd1);
        chk("vga_last_rdata", bus.vga_rdata, sh_word(a + 32'(4 * (BL - 1))));
        @(negedge clk);
        chk("vga_rvalid_off", 32'(bus.vga_rvalid), 32'd0);
    endtask

    task automatic starve_test();
        int   w, nv;
        logic got_cpu;
        bus.cpu_we   = 1'b0;
        bus.cpu_size = 2'd2;
        bus.cpu_addr = 32'h20;
        bus.vga_addr = 32'h80;
        bus.cpu_req  = 1'b1;
        bus.vga_req  = 1'b1;
        nv = 0;
        got_cpu = 1'b0;
        w = 0;
        while (!got_cpu && w < 200) begin
            @(negedge clk);
            w++;
            if (bus.vga_gnt) nv++;
            if (bus.cpu_gnt) begin
                got_cpu = 1'b1;
                bus.cpu_req = 1'b0;
            end
        end
        chk("starve_cpu_granted", 32'(got_cpu), 32'd1);
        chk("starve_bursts_before_cpu", 32'(nv), 32'((SL + BL) / (BL + 1)));
        @(negedge clk);
        chk("starve_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
        chk("starve_cpu_rdata", bus.cpu_rdata, sh_word(32'h20));
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.vga_gnt && !bus.cpu_gnt && w < 20);
        bus.vga_req = 1'b0;
        chk("starve_next_is_vga", 32'(bus.vga_gnt), 32'd1);
        repeat (BL + 3) @(negedge clk);
    endtask

    task automatic reset_mid_burst();
        bus.vga_addr = 32'h40;
        bus.vga_req  = 1'b1;
        @(negedge clk);
        bus.vga_req = 1'b0;
        chk("rst_beat0_gnt", 32'(bus.vga_gnt), 32'd1);
        repeat (3) @(negedge clk);
        chk("rst_beat3_addr", bus.mem_addr, 32'h4c);
        reset = 1'b1;
        @(negedge clk);
        chk_zero("rst_mid");
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_rvalid", 32'(bus.vga_rvalid), 32'd0);
            chk("rst_no_mem_en", 32'(bus.mem_en), 32'd0);
        end
        vga_burst(32'h40);
    endtask

    initial begin
        logic [31:0] r;
        reset         = 1'b1;
        mem_init      = 1'b1;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_size  = '0;
        bus.vga_req   = 1'b0;
        bus.vga_addr  = '0;
        for (int i = 0; i < 64; i++) begin
            r = init_word(i);
            for (int b = 0; b < 4; b++) sh[4 * i + b] = r[31 - 8 * b -: 8];
        end
        repeat (2) @(negedge clk);
        chk_zero("reset");
        mem_init = 1'b0;
        reset    = 1'b0;
        @(negedge clk);

        cpu_access(1'b1, 2'd2, 32'h10, 32'hdeadbeef);
        cpu_access(1'b0, 2'd2, 32'h10, 32'h0);
        cpu_access(1'b1, 2'd0, 32'h13, 32'h000000a5);
        cpu_access(1'b1, 2'd1, 32'h12, 32'h00001234);
        cpu_access(1'b0, 2'd2, 32'h10, 32'h0);
        cpu_access(1'b1, 2'd1, 32'h11, 32'h0000cafe);
        cpu_access(1'b0, 2'd3, 32'h22, 32'h0);
        vga_burst(32'h40);
        vga_burst(32'hfffffff8);
        starve_test();
        reset_mid_burst();

        repeat (80) begin
            if ($urandom_range(0, 4) == 0) begin
                r = $urandom();
                vga_burst({r[31:2], 2'b00});
            end else begin
                cpu_access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                           $urandom(), $urandom());
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
